// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per clock, plus a final fix-up cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  Op,
    input  logic        Start,
    input  logic        HiWrite,
    input  logic        LoWrite,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t r_state, w_state_nxt;

    logic        r_is_div, r_neg_q, r_neg_r;
    logic [31:0] r_acc, r_shf, r_opd;
    logic [4:0]  r_cnt;

    logic signed [31:0] w_a_s, w_b_s;
    logic        w_signed, w_a_neg, w_b_neg, w_divz;
    logic [31:0] w_abs_a, w_abs_b;
    logic        w_accept, w_step, w_fix, w_zero_div;
    logic [32:0] w_madd, w_rsh, w_rdif;
    logic        w_qbit;
    logic [63:0] w_prod;

    function automatic logic [31:0] cneg32(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

    // Operand conditioning for the edge that accepts Start
    assign w_a_s      = A;
    assign w_b_s      = B;
    assign w_signed   = ~Op[0];
    assign w_a_neg    = w_signed & (w_a_s < 0);
    assign w_b_neg    = w_signed & (w_b_s < 0);
    assign w_abs_a    = cneg32(w_a_neg, A);
    assign w_abs_b    = cneg32(w_b_neg, B);
    assign w_zero_div = Op[1] & (B == 32'd0);

    // Step datapath: r_shf holds multiplier bits (mul) or dividend/quotient bits (div)
    assign w_madd = {1'b0, r_acc} + (r_shf[0] ? {1'b0, r_opd} : 33'd0);
    assign w_rsh  = {r_acc, r_shf[31]};
    assign w_rdif = w_rsh - {1'b0, r_opd};
    assign w_qbit = ~w_rdif[32];
    assign w_prod = cneg64(r_neg_q, {r_acc, r_shf});

    assign Busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_fix       = 1'b0;
        w_divz      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (w_zero_div) begin
                        w_divz = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == 5'd31) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= 32'd0;
            r_shf    <= 32'd0;
            r_opd    <= 32'd0;
            r_cnt    <= 5'd0;
            Done     <= 1'b0;
            DivZero  <= 1'b0;
            Hi       <= 32'd0;
            Lo       <= 32'd0;
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            if (w_divz) begin
                Hi      <= A;
                Lo      <= 32'hFFFF_FFFF;
                Done    <= 1'b1;
                DivZero <= 1'b1;
            end else if (w_accept) begin
                r_is_div <= Op[1];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_shf    <= w_abs_a;
                r_opd    <= w_abs_b;
                r_acc    <= 32'd0;
                r_cnt    <= 5'd0;
            end else if (w_step) begin
                if (r_is_div) begin
                    r_acc <= w_qbit ? w_rdif[31:0] : w_rsh[31:0];
                    r_shf <= {r_shf[30:0], w_qbit};
                end else begin
                    r_acc <= w_madd[32:1];
                    r_shf <= {w_madd[0], r_shf[31:1]};
                end
                r_cnt <= r_cnt + 5'd1;
            end else if (w_fix) begin
                if (r_is_div) begin
                    Lo <= cneg32(r_neg_q, r_shf);
                    Hi <= cneg32(r_neg_r, r_acc);
                end else begin
                    Hi <= w_prod[63:32];
                    Lo <= w_prod[31:0];
                end
                Done <= 1'b1;
            end else if (r_state == S_IDLE) begin
                if (HiWrite) Hi <= A;
                if (LoWrite) Lo <= A;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a monitor checks them on Done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [1:0]  Op;
    logic        Start, HiWrite, LoWrite;
    logic        Busy, Done, DivZero;
    logic [31:0] Hi, Lo;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op),
        .Start(Start), .HiWrite(HiWrite), .LoWrite(LoWrite),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi, m_lo;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural operands
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa, sbv, sp;
        logic [63:0] up;
        int x, y;
        e.dz = 1'b0;
        e.hi = 32'd0;
        e.lo = 32'd0;
        case (op)
            2'b00: begin
                sa = $signed(a);
                sbv = $signed(b);
                sp = sa * sbv;
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else if (op == 2'b11) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'd0;
                end else begin
                    x = a;
                    y = b;
                    e.lo = 32'(x / y);
                    e.hi = 32'(x % y);
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && Done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got Done=1 expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                chk("sb_hi", 64'(Hi), 64'(mon_e.hi));
                chk("sb_lo", 64'(Lo), 64'(mon_e.lo));
                chk("sb_divzero", 64'(DivZero), 64'(mon_e.dz));
            end
        end
    end

    // Issues one operation; called at a falling edge, returns at the falling edge that shows Done
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb, input bit wr_with_start);
        exp_t        e;
        int          busy_n;
        bit          seen, held;
        logic [31:0] ph, pl;
        e = model(op, a, b);
        sb.push_back(e);
        ph = m_hi;
        pl = m_lo;
        held = 1'b1;
        seen = 1'b0;
        busy_n = 0;
        Op = op;
        A = a;
        B = b;
        Start = 1'b1;
        HiWrite = wr_with_start;
        LoWrite = wr_with_start;
        @(posedge clk);
        #1;
        Start = 1'b0;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        A = $urandom;
        B = $urandom;
        Op = 2'($urandom);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (Busy === 1'b1) busy_n++;
            if (Hi !== ph || Lo !== pl) held = 1'b0;
            if (disturb) begin
                Start = 1'($urandom);
                HiWrite = 1'($urandom);
                LoWrite = 1'($urandom);
            end
            A = $urandom;
            B = $urandom;
            Op = 2'($urandom);
        end
        Start = 1'b0;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_cycles", 64'(busy_n), e.dz ? 64'd0 : 64'd33);
        chk("hilo_hold", 64'(held), 64'd1);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic mt(input bit hw, input bit lw, input logic [31:0] a);
        HiWrite = hw;
        LoWrite = lw;
        A = a;
        @(posedge clk);
        #1;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        if (hw) m_hi = a;
        if (lw) m_lo = a;
        @(negedge clk);
        chk("mt_hi", 64'(Hi), 64'(m_hi));
        chk("mt_lo", 64'(Lo), 64'(m_lo));
    endtask

    function automatic logic [31:0] pick(input bit allow_zero);
        case ($urandom_range(7, 0))
            0: return allow_zero ? 32'd0 : 32'd5;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        Start = 1'b0;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        A = 32'd0;
        B = 32'd0;
        Op = 2'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        #12;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_divzero", 64'(DivZero), 64'd0);
        chk("rst_hi", 64'(Hi), 64'd0);
        chk("rst_lo", 64'(Lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max_hi", 64'(Hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_max_lo", 64'(Lo), 64'h0000_0000_0000_0001);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        chk("mult_neg_hi", 64'(Hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_neg_lo", 64'(Lo), 64'h0000_0000_FFFF_FFEB);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_neg_lo", 64'(Lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_neg_hi", 64'(Hi), 64'h0000_0000_FFFF_FFFF);
        do_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
        chk("divu_lo", 64'(Lo), 64'd3);
        chk("divu_hi", 64'(Hi), 64'd1);
        do_op(2'b10, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        chk("dz_hi", 64'(Hi), 64'h0000_0000_1234_5678);
        chk("dz_lo", 64'(Lo), 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        chk("dz_pulse_end", 64'(DivZero), 64'd0);
        chk("dz_done_end", 64'(Done), 64'd0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf_lo", 64'(Lo), 64'h0000_0000_8000_0000);
        chk("div_ovf_hi", 64'(Hi), 64'd0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("divu_big_lo", 64'(Lo), 64'd0);
        chk("divu_big_hi", 64'(Hi), 64'h0000_0000_8000_0000);

        do_op(2'b01, 32'd5, 32'd6, 1'b1, 1'b0);
        chk("disturb_lo", 64'(Lo), 64'h1E);
        mt(1'b1, 1'b0, 32'hAABB_CCDD);
        mt(1'b0, 1'b1, 32'h0102_0304);
        do_op(2'b00, 32'd9, 32'd9, 1'b0, 1'b1);

        mt(1'b1, 1'b1, 32'h1111_1111);
        Op = 2'b01;
        A = 32'd5;
        B = 32'd6;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_hi", 64'(Hi), 64'd0);
        chk("abort_lo", 64'(Lo), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(2'b01, 32'd5, 32'd6, 1'b0, 1'b0);
        chk("post_rst_hi", 64'(Hi), 64'd0);
        chk("post_rst_lo", 64'(Lo), 64'h1E);

        for (int n = 0; n < 40; n++) begin
            do_op(2'($urandom), pick(1'b1), pick(1'b1), 1'($urandom), ($urandom_range(3, 0) == 0));
        end

        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 A  input  32  operand A (dividend / multiplicand); also the data source for HI/LO writes.
REQ-005 B  input  32  operand B (divisor / multiplier).
REQ-006 Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Start  input  1  begin the operation in Op on A and B.
REQ-008 HiWrite  input  1  load Hi from A (MTHI).
REQ-009 LoWrite  input  1  load Lo from A (MTLO).
REQ-010 Busy  output  1  operation in progress.
REQ-011 Done  output  1  one-cycle pulse when Hi/Lo receive a result.
REQ-012 DivZero  output  1  one-cycle pulse on divide by zero.
REQ-013 Hi  output  32  HI register.
REQ-014 Lo  output  32  LO register.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FIX; Busy=1 exactly in RUN and FIX.
REQ-016 Start SHALL only be accepted in IDLE; edge E0 that samples it SHALL latch Op, sign flags and the absolute values of A and B, clear the iteration counter and enter RUN.
REQ-017 Magnitudes: signed ops SHALL use |A| and |B|; unsigned ops SHALL use the raw values; |0x80000000| SHALL be 0x80000000 unsigned.
REQ-018 RUN SHALL perform one iteration per edge, E1..E32: a shift-add step for multiply, a restoring shift-subtract step (33-bit partial remainder) for divide; at E32 the FSM SHALL go to FIX.
REQ-019 At E33 (FIX), multiply SHALL write {Hi,Lo}=64-bit product, negated when signed and sign(A)!=sign(B); Done=1 for that one cycle; FSM returns to IDLE, Busy=0.
REQ-020 At E33, divide SHALL write Lo=quotient, negated when signed and sign(A)!=sign(B); Hi=remainder, negated when signed and A<0.
REQ-021 Signed DIV 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0x00000000, with no flag.
REQ-022 Divide by zero (DIV/DIVU with B=0 on Start in IDLE) SHALL skip RUN: at E0 write Hi=A and Lo=0xFFFFFFFF, and assert DivZero=1 and Done=1 for one cycle; Busy SHALL stay 0.
REQ-023 Hi/Lo SHALL hold their previous values throughout RUN; partial results SHALL never be visible.
REQ-024 Changes on A, B and Op during Busy SHALL have no effect.
REQ-025 Start, HiWrite and LoWrite asserted while Busy=1 SHALL be ignored; no queuing.
REQ-026 In IDLE without Start, HiWrite SHALL load Hi<=A and LoWrite SHALL load Lo<=A on the next edge; both asserted SHALL load both.
REQ-027 In IDLE, Start together with HiWrite/LoWrite SHALL let Start win; the writes are ignored.
REQ-028 Total latency: Busy high for 33 cycles; result registered at E33; back-to-back Start is accepted in the cycle after Done.

Reset
REQ-029 reset=0 SHALL immediately force: state IDLE, Busy=0, Done=0, DivZero=0, Hi=0, Lo=0, counter=0, operand registers=0.
REQ-030 Reset asserted mid-operation SHALL abort it with no Hi/Lo update; the first Start after release SHALL behave as from power-up.

Verification
REQ-031 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Busy 33 cycles, at E33 Hi=0xFFFFFFFE Lo=0x00000001, Done pulse.
REQ-032 MULT A=0xFFFFFFFD(-3) B=0x00000007 -> Hi=0xFFFFFFFF Lo=0xFFFFFFEB; DIV A=0xFFFFFFF9(-7) B=2 -> Lo=0xFFFFFFFD Hi=0xFFFFFFFF; DIVU A=7 B=2 -> Lo=3 Hi=1.
REQ-033 DIV A=0x12345678 B=0 -> next edge Hi=0x12345678 Lo=0xFFFFFFFF, DivZero=1 and Done=1 for one cycle, Busy never 1.
REQ-034 DIV A=0x80000000 B=0xFFFFFFFF -> Lo=0x80000000 Hi=0; DIVU same operands -> Lo=0 Hi=0x80000000.
REQ-035 Hi=Lo=0x11111111, start MULTU 5*6, assert reset at RUN iteration 10 -> Busy=0 and Hi=Lo=0 immediately; after release, MULTU 5*6 -> Hi=0 Lo=0x1E at E33.
REQ-036 Start and HiWrite pulsed during RUN -> ignored, result unchanged; then in IDLE, HiWrite with A=0xAABBCCDD -> Hi=0xAABBCCDD next edge, Lo unchanged.
